// File: rtl/cache_control.sv
// -----------------------------------------------------------------------------
// cache_control
//   Control FSM for a 2-way set-associative, write-back, write-allocate cache.
//   The datapath supplies the hit, dirty and LRU status of the indexed set.
//   This block returns the data/metadata write strobes, the physical-memory
//   handshake and the CPU response.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   mem_read, mem_write       CPU request, held until mem_resp
//   mem_byte_enable           CPU write byte mask
//   mem_resp                  one-cycle request-done pulse
//   hit, dirty, lru           per-way status of the indexed set (datapath)
//   pmem_read, pmem_write     physical memory line strobes
//   pmem_resp                 physical memory done pulse
//   way_we0, way_we1          byte write masks for the two data arrays
//   data_src                  data array source: 0 = CPU data, 1 = pmem line
//   addr_src                  pmem address: 0 = CPU address, 1 = victim line
//   tag_load, valid_set,
//   dirty_set, dirty_clr      per-way metadata strobes
//   lru_load, lru_in          LRU write strobe and value
//   victim                    latched victim way (writeback data mux select)
// -----------------------------------------------------------------------------
module cache_control #(
  parameter int s_offset = 5,
  parameter int s_index  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [(2**s_offset)-1:0] mem_byte_enable,
  output logic                     mem_resp,
  input  logic [1:0]               hit,
  input  logic [1:0]               dirty,
  input  logic                     lru,
  output logic                     pmem_read,
  output logic                     pmem_write,
  input  logic                     pmem_resp,
  output logic [(2**s_offset)-1:0] way_we0,
  output logic [(2**s_offset)-1:0] way_we1,
  output logic                     data_src,
  output logic                     addr_src,
  output logic [1:0]               tag_load,
  output logic [1:0]               valid_set,
  output logic [1:0]               dirty_set,
  output logic [1:0]               dirty_clr,
  output logic                     lru_load,
  output logic                     lru_in,
  output logic                     victim
);

  // The set count only shapes the datapath. A negative value is meaningless,
  // so an empty marker block is the only thing it can select here.
  if (s_index < 0) begin : g_bad_index
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   victim_q, victim_d;
  logic   req;
  logic   hit_way;

  assign req     = mem_read | mem_write;
  // Way 0 takes priority when both ways report a hit.
  assign hit_way = ~hit[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    way_we0    = '0;
    way_we1    = '0;
    data_src   = 1'b0;
    addr_src   = 1'b0;
    tag_load   = 2'b00;
    valid_set  = 2'b00;
    dirty_set  = 2'b00;
    dirty_clr  = 2'b00;
    lru_load   = 1'b0;
    lru_in     = 1'b0;
    victim     = 1'b0;
    // While reset is high every strobe stays low. This means a pmem_resp that
    // coincides with reset cannot commit a fill or clear metadata.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (|hit) begin
              mem_resp = 1'b1;
              lru_load = 1'b1;
              lru_in   = ~hit_way;
              // A write takes precedence when read and write are both high.
              if (mem_write) begin
                data_src           = 1'b0;
                dirty_set[hit_way] = 1'b1;
                if (hit_way) way_we1 = mem_byte_enable;
                else         way_we0 = mem_byte_enable;
              end
            end else begin
              victim_d = lru;
              state_d  = dirty[lru] ? WRITEBACK : ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          pmem_write = 1'b1;
          addr_src   = 1'b1;
          victim     = victim_q;
          if (pmem_resp) begin
            dirty_clr[victim_q] = 1'b1;
            state_d             = ALLOCATE;
          end
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          addr_src  = 1'b0;
          victim    = victim_q;
          if (pmem_resp) begin
            data_src            = 1'b1;
            tag_load[victim_q]  = 1'b1;
            valid_set[victim_q] = 1'b1;
            dirty_clr[victim_q] = 1'b1;
            if (victim_q) way_we1 = '1;
            else          way_we0 = '1;
            // Back to IDLE, which sees the line as a hit. A write miss then
            // merges its bytes over the freshly filled line.
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 Parameter s_offset, default 5, log2 of line size in bytes (32-byte line).
REQ-002 Parameter s_index, default 3, log2 of number of sets; no effect on control logic, carried for datapath consistency.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 mem_read  input  1  CPU line read request, held until mem_resp.
REQ-006 mem_write  input  1  CPU write request, held until mem_resp.
REQ-007 mem_byte_enable  input  2**s_offset  CPU write byte mask.
REQ-008 mem_resp  output  1  one-cycle request-done pulse.
REQ-009 hit  input  2  per-way tag match qualified by valid, from datapath, combinational on the current address.
REQ-010 dirty  input  2  per-way dirty bits of the indexed set.
REQ-011 lru  input  1  indexed set's LRU way (0 = way0 least recent).
REQ-012 pmem_read / pmem_write  output  1 each  physical memory line strobes.
REQ-013 pmem_resp  input  1  physical memory done pulse.
REQ-014 way_we0 / way_we1  output  2**s_offset each  byte write masks to the two data arrays.
REQ-015 data_src  output  1  data array write source: 0 = CPU data, 1 = pmem line.
REQ-016 addr_src  output  1  pmem address: 0 = CPU address, 1 = victim tag + index.
REQ-017 tag_load, valid_set, dirty_set, dirty_clr  output  2 each  per-way metadata strobes.
REQ-018 lru_load  output  1  LRU write strobe; lru_in  output  1  new LRU value.
REQ-019 victim  output  1  registered victim way; selects the writeback data mux.

Function
REQ-020 States IDLE, WRITEBACK, ALLOCATE; all outputs not named for a state SHALL be 0 in that state.
REQ-021 IDLE, no request: all outputs 0, remain IDLE.
REQ-022 IDLE, request, hit nonzero: hit way h = way0 if hit[0], else way1; mem_resp=1 same cycle; lru_load=1, lru_in = ~h; remain IDLE.
REQ-023 Write hit additionally: way_we<h> = mem_byte_enable, data_src=0, dirty_set[h]=1; the other way's mask = 0.
REQ-024 mem_read and mem_write both high SHALL be treated as a write.
REQ-025 IDLE, request, hit = 0: victim register <= lru; next state WRITEBACK if dirty[lru] else ALLOCATE; mem_resp=0.
REQ-026 WRITEBACK: pmem_write=1, addr_src=1 every cycle; on pmem_resp: dirty_clr[victim]=1, next state ALLOCATE.
REQ-027 ALLOCATE: pmem_read=1, addr_src=0 every cycle; on pmem_resp: way_we<victim> = all ones, data_src=1, tag_load/valid_set/dirty_clr[victim]=1, next state IDLE.
REQ-028 After ALLOCATE, IDLE re-evaluates hit; the request completes as a hit (REQ-022/023), so a write miss merges CPU bytes after the fill.
REQ-029 Latency: hit 0 cycles after request sample; clean miss with pmem_resp k cycles after pmem_read rises: mem_resp at cycle k+2 after request; dirty miss adds writeback duration + 1.
REQ-030 Request dropped during WRITEBACK/ALLOCATE: sequence runs to completion, no mem_resp is issued.
REQ-031 pmem_resp in IDLE SHALL be ignored.
REQ-032 Request still high the cycle after mem_resp SHALL be treated as a new request.

Reset
REQ-033 rst high at a clock edge: state <= IDLE, victim <= 0; from the next cycle all outputs 0.
REQ-034 rst mid-WRITEBACK or mid-ALLOCATE: pmem strobes drop next cycle; no metadata or data write occurs; pmem_resp in the same cycle as rst SHALL be ignored.

Verification
REQ-035 Read hit way1 (hit=10) -> mem_resp=1 same cycle, lru_load=1, lru_in=0, way_we0/1=0.
REQ-036 Write hit way0, mask 0x0000000F -> way_we0=0x0000000F, dirty_set=01, data_src=0, mem_resp=1.
REQ-037 Clean read miss, lru=1, dirty=00, pmem_resp 3 cycles after pmem_read -> ALLOCATE; way_we1=all ones, tag_load=10; then hit, mem_resp.
REQ-038 Dirty write miss, lru=0, dirty=01 -> pmem_write with addr_src=1 until resp, dirty_clr=01, then ALLOCATE fill of way0, then write hit sets dirty_set=01.
REQ-039 rst asserted during ALLOCATE with pmem_resp concurrent -> no way_we/tag_load; IDLE, all outputs 0 next cycle.
REQ-040 Read+write asserted with a hit -> write behavior (REQ-023), single mem_resp pulse.
